// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared types and constants for the bit-serial adder/subtracter.
//   - state_t        : controller states (IDLE, BUSY, DONE)
//   - DEFAULT_WIDTH  : default operand/result width
//   - cnt_width()    : width of the bit counter for a given operand width
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
//   Single-bit full-adder cell used by the serial datapath.
//   Ports:
//     a, b, cin : addend bits and carry in
//     s         : sum bit
//     cout      : carry out (majority of the three inputs)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_subtracter.sv
// serial_adder_subtracter
//   Bit-serial two's-complement add/subtract, one bit per clock, LSB first,
//   through a single full-adder cell. Request and result use valid/ready.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     in_valid / in_ready  : request handshake (a, b, s sampled on accept)
//     a, b                 : WIDTH-bit operands
//     s                    : 0 = a+b, 1 = a-b
//     out_valid / out_ready: result handshake
//     sum                  : WIDTH-bit result
//     v                    : signed overflow
//     z, n                 : zero / negative flags (only with
//                            SERIAL_ADDSUB_FLAGS_EN defined)
//   Optional feature macro: SERIAL_ADDSUB_FLAGS_EN
module serial_adder_subtracter
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDSUB_FLAGS_EN
    output logic             z,
    output logic             n,
`endif
    output logic             v
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             v_r;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_nxt;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 lands at sum[0].
    assign sum_nxt = {fa_s, sum_r[WIDTH-1:1]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign v         = v_r;

`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic z_r;
    logic n_r;
    assign z = z_r;
    assign n = n_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            sum_r <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            v_r   <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            z_r   <= 1'b0;
            n_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract = add the inverted operand with carry-in 1.
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{s}};
                        carry <= s;
                        cnt   <= '0;
                        sum_r <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum_r <= sum_nxt;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here.
                        v_r   <= carry ^ fa_co;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                        z_r   <= (sum_nxt == '0);
                        n_r   <= fa_s;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_subtracter.sv
module tb_serial_adder_subtracter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sum;
    logic       v;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic       z;
    logic       n;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder_subtracter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDSUB_FLAGS_EN
        .z         (z),
        .n         (n),
`endif
        .v         (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request from IDLE, waits (bounded) for the result, captures
    // it on a negedge, then completes the result handshake.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                         output logic [3:0] rsum, output logic rv,
                         output logic rz, output logic rn,
                         output int lat, output bit seen);
        @(negedge clk);
        a = ta; b = tb_; s = ts; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; a = 4'hx; b = 4'hx; s = 1'bx;
        lat = 0; seen = 0;
        rsum = 'x; rv = 'x; rz = 'x; rn = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                rsum = sum; rv = v;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                rz = z; rn = n;
`endif
                break;
            end
            lat++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        a = 4'h0; b = 4'h0; s = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if (sum !== 4'b0000 || v !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: sum=%b v=%b want 0000 0", sum, v);
        end
`ifdef SERIAL_ADDSUB_FLAGS_EN
        checks++;
        if (z !== 1'b0 || n !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: z=%b n=%b want 0 0", z, n);
        end
`endif
    endtask

    task automatic test_add_latency();
        logic [3:0] rs; logic rv, rz, rn; int lat; bit seen;
        do_op(4'b0001, 4'b0011, 1'b0, rs, rv, rz, rn, lat, seen);
        checks++;
        if (!seen || lat != 4) begin
            failures++;
            $display("FAIL add_latency: seen=%0d lat=%0d want 1 4", seen, lat);
        end
        checks++;
        if (rs !== 4'b0100 || rv !== 1'b0) begin
            failures++;
            $display("FAIL add_1p3: sum=%b v=%b want 0100 0", rs, rv);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_idle_after: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    // Table of directed vectors: {a, b, s, sum, v, z, n}
    task automatic test_vectors();
        logic [3:0] ta [6]  = '{4'b0100, 4'b0010, 4'b0100, 4'b1100, 4'b0000, 4'b1111};
        logic [3:0] tbv[6]  = '{4'b0010, 4'b0100, 4'b0110, 4'b1010, 4'b1000, 4'b1000};
        logic       ts [6]  = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b1,    1'b1};
        logic [3:0] es [6]  = '{4'b0010, 4'b1110, 4'b1010, 4'b0110, 4'b1000, 4'b0111};
        logic       ev [6]  = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0};
        logic       en [6]  = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b1,    1'b0};
        logic [3:0] rs; logic rv, rz, rn; int lat; bit seen;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tbv[i], ts[i], rs, rv, rz, rn, lat, seen);
            checks++;
            if (!seen || rs !== es[i] || rv !== ev[i]) begin
                failures++;
                $display("FAIL vec%0d: seen=%0d sum=%b v=%b want sum=%b v=%b",
                         i, seen, rs, rv, es[i], ev[i]);
            end
`ifdef SERIAL_ADDSUB_FLAGS_EN
            checks++;
            if (rz !== 1'b0 || rn !== en[i]) begin
                failures++;
                $display("FAIL vec%0d_flags: z=%b n=%b want 0 %b", i, rz, rn, en[i]);
            end
`else
            if (en[i] === 1'bx) $display("unexpected table entry");
`endif
        end
    endtask

    task automatic test_back_to_back_hold();
        bit seen;
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; s = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL hold_wait: out_valid never rose");
        end
        // Stall the consumer while wiggling request inputs.
        for (int i = 0; i < 5; i++) begin
            a = 4'(i * 3 + 5); b = 4'(i + 9); s = i[0]; in_valid = ~i[0];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 4'b0010 || v !== 1'b0) begin
                failures++;
                $display("FAIL hold_cyc%0d: in_ready=%b out_valid=%b sum=%b v=%b want 0 1 0010 0",
                         i, in_ready, out_valid, sum, v);
            end
        end
        // Release consumer with the next request already pending.
        a = 4'b0011; b = 4'b0001; s = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL next_accept: in_ready=%b want 0", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen || sum !== 4'b0100 || v !== 1'b0) begin
            failures++;
            $display("FAIL next_result: seen=%0d sum=%b v=%b want 1 0100 0", seen, sum, v);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [3:0] rs; logic rv, rz, rn; int lat; bit seen;
        @(negedge clk);
        a = 4'b0111; b = 4'b0001; s = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 4'b0000 || in_ready !== 1'b1 || v !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b sum=%b in_ready=%b v=%b want 0 0000 1 0",
                     out_valid, sum, in_ready, v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                failures++;
                $display("FAIL mid_reset_emit: out_valid=1 after reset want 0");
                break;
            end
        end
        do_op(4'b0011, 4'b0011, 1'b1, rs, rv, rz, rn, lat, seen);
        checks++;
        if (!seen || rs !== 4'b0000 || rv !== 1'b0) begin
            failures++;
            $display("FAIL sub_3m3: seen=%0d sum=%b v=%b want 1 0000 0", seen, rs, rv);
        end
`ifdef SERIAL_ADDSUB_FLAGS_EN
        checks++;
        if (rz !== 1'b1 || rn !== 1'b0) begin
            failures++;
            $display("FAIL sub_3m3_flags: z=%b n=%b want 1 0", rz, rn);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 4'h0; b = 4'h0; s = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_add_latency();
        test_vectors();
        test_back_to_back_hold();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
